mips_decoder: RTL and testbench



---
 rtl/mips_decoder_pkg.sv | 69 ++++++
 rtl/mips_decoder_decode_hazard.sv | 46 ++++
 rtl/mips_decoder.sv | 161 ++++++++++++++++
 tb/tb_mips_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_decoder_pkg.sv
// Shared decode definitions for the MIPS-lite pipeline decoders:
// opcode/funct constants, control-field encodings and the one-hot
// "recognised instruction" record passed to the hazard-timing block.
package mips_decoder_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Extender modes
  localparam logic [3:0] zero_ext   = 4'd0;
  localparam logic [3:0] sign_ext   = 4'd1;
  localparam logic [3:0] tohigh_ext = 4'd2;
  localparam logic [3:0] none_ext   = 4'd15;

  // Next-PC modes
  localparam logic [2:0] seq_npc    = 3'd0;
  localparam logic [2:0] bType_npc  = 3'd1;
  localparam logic [2:0] jType_npc  = 3'd2;
  localparam logic [2:0] rType_npc  = 3'd3;

  // ALU operations
  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_OR     = 3'd2;

  // Write-back data source
  localparam logic [1:0] WD_ALU     = 2'd0;
  localparam logic [1:0] WD_MEM     = 2'd1;
  localparam logic [1:0] WD_PC8     = 2'd2;

  // Link register written by jal
  localparam logic [4:0] REG_RA     = 5'd31;

  // Hazard timing: "operand never read"
  localparam logic [1:0] TUSE_NONE  = 2'd3;

  // One bit per recognised instruction; all-zero means illegal
  typedef struct packed {
    logic nop;
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
  } instr_hit_t;

  // True when the encoding matched a supported instruction
  function automatic logic is_recognised(input instr_hit_t hit);
    return |hit;
  endfunction

endpackage

// File: rtl/mips_decoder_decode_hazard.sv
// Hazard-timing lookup: maps the recognised instruction to the number of
// cycles until each source operand is needed (Tuse) and until the result
// is available (Tnew, counted from the D stage). Illegal encodings and
// instructions that do not touch an operand report TUSE_NONE / Tnew 0,
// which is the same as a nop.
module decode_hazard
  import mips_decoder_pkg::*;
(
  input  instr_hit_t  hit_i,
  output logic [1:0]  tuse_rs_o,
  output logic [1:0]  tuse_rt_o,
  output logic [1:0]  tnew_o
);

  // rs consumption: branches/jr compare in D, ALU and address users in E
  always_comb begin
    tuse_rs_o = TUSE_NONE;
    if (hit_i.beq || hit_i.jr)
      tuse_rs_o = 2'd0;
    else if (hit_i.addu || hit_i.subu || hit_i.ori || hit_i.lw || hit_i.sw)
      tuse_rs_o = 2'd1;
  end

  // rt consumption: beq in D, ALU ops in E, store data only in M
  always_comb begin
    tuse_rt_o = TUSE_NONE;
    if (hit_i.beq)
      tuse_rt_o = 2'd0;
    else if (hit_i.addu || hit_i.subu)
      tuse_rt_o = 2'd1;
    else if (hit_i.sw)
      tuse_rt_o = 2'd2;
  end

  // Result production: ALU results leave E, loads leave M, jal's PC+8 in D
  always_comb begin
    tnew_o = 2'd0;
    if (hit_i.addu || hit_i.subu || hit_i.ori || hit_i.lui)
      tnew_o = 2'd2;
    else if (hit_i.lw)
      tnew_o = 2'd3;
    else if (hit_i.jal)
      tnew_o = 2'd1;
  end

endmodule

// File: rtl/mips_decoder.sv
// Main instruction decoder for the five-stage MIPS-lite pipeline.
// Decode is purely combinational; the clock only updates a sticky
// illegal-instruction flag for debug.
// Optional feature: define DECODE_HAZARD_EN to drive Tuse_rs/Tuse_rt/Tnew
// from the decode_hazard lookup; otherwise those ports are tied to 0.
module mips_decoder
  import mips_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic [2:0]  ALUOp,
  output logic [3:0]  EXTOp,
  output logic [2:0]  NPCOp,
  output logic [1:0]  WDSel,
  output logic [4:0]  A3,
  output logic [1:0]  Tuse_rs,
  output logic [1:0]  Tuse_rt,
  output logic [1:0]  Tnew,
  output logic        illegal,
  output logic        illegal_seen
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;

  instr_hit_t hit;
  logic       reg_write;
  logic [4:0] dest_reg;
  logic       illegal_seen_q;
  logic       illegal_seen_d;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];

  // Classify the instruction; anything unmatched (including X/Z) leaves hit all-zero
  always_comb begin
    hit = '0;
    if (instr == 32'd0) begin
      hit.nop = 1'b1;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          case (funct)
            FN_ADDU: hit.addu = 1'b1;
            FN_SUBU: hit.subu = 1'b1;
            FN_JR:   hit.jr   = 1'b1;
            default: ;
          endcase
        end
        OP_ORI:  hit.ori = 1'b1;
        OP_LW:   hit.lw  = 1'b1;
        OP_SW:   hit.sw  = 1'b1;
        OP_BEQ:  hit.beq = 1'b1;
        OP_LUI:  hit.lui = 1'b1;
        OP_J:    hit.j   = 1'b1;
        OP_JAL:  hit.jal = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal = ~is_recognised(hit);

  // Datapath controls; starts from the nop value so illegal words stay inert
  always_comb begin
    reg_write = 1'b0;
    MemWrite  = 1'b0;
    ALUSrc    = 1'b0;
    ALUOp     = ALU_ADD;
    EXTOp     = none_ext;
    NPCOp     = seq_npc;
    WDSel     = WD_ALU;
    dest_reg  = 5'd0;
    if (hit.addu || hit.subu) begin
      reg_write = 1'b1;
      ALUOp     = hit.subu ? ALU_SUB : ALU_ADD;
      WDSel     = WD_ALU;
      dest_reg  = rd;
    end
    if (hit.ori) begin
      reg_write = 1'b1;
      ALUSrc    = 1'b1;
      ALUOp     = ALU_OR;
      EXTOp     = zero_ext;
      dest_reg  = rt;
    end
    if (hit.lui) begin
      reg_write = 1'b1;
      ALUSrc    = 1'b1;
      ALUOp     = ALU_ADD;
      EXTOp     = tohigh_ext;
      dest_reg  = rt;
    end
    if (hit.lw) begin
      reg_write = 1'b1;
      ALUSrc    = 1'b1;
      EXTOp     = sign_ext;
      WDSel     = WD_MEM;
      dest_reg  = rt;
    end
    if (hit.sw) begin
      MemWrite  = 1'b1;
      ALUSrc    = 1'b1;
      EXTOp     = sign_ext;
    end
    if (hit.beq) begin
      NPCOp     = bType_npc;
      EXTOp     = sign_ext;
    end
    if (hit.j) begin
      NPCOp     = jType_npc;
    end
    if (hit.jal) begin
      NPCOp     = jType_npc;
      reg_write = 1'b1;
      WDSel     = WD_PC8;
      dest_reg  = REG_RA;
    end
    if (hit.jr) begin
      NPCOp     = rType_npc;
    end
  end

  // Destination is forced to $0 whenever no register is written
  assign RegWrite = reg_write;
  assign A3       = reg_write ? dest_reg : 5'd0;

`ifdef DECODE_HAZARD_EN
  decode_hazard u_decode_hazard (
    .hit_i     (hit),
    .tuse_rs_o (Tuse_rs),
    .tuse_rt_o (Tuse_rt),
    .tnew_o    (Tnew)
  );
`else
  assign Tuse_rs = 2'd0;
  assign Tuse_rt = 2'd0;
  assign Tnew    = 2'd0;
`endif

  assign illegal_seen_d = illegal_seen_q | illegal;

  // Sticky debug flag: latches any illegal decode, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      illegal_seen_q <= 1'b0;
    else
      illegal_seen_q <= illegal_seen_d;
  end

  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_mips_decoder.sv
// Bench for mips_decoder: hand-written vector table, sticky-flag sequences
// and a randomized run against a mnemonic-level reference model.
module tb_mips_decoder;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        RegWrite, MemWrite, ALUSrc, illegal, illegal_seen;
  logic [2:0]  ALUOp, NPCOp;
  logic [3:0]  EXTOp;
  logic [1:0]  WDSel, Tuse_rs, Tuse_rt, Tnew;
  logic [4:0]  A3;

  int checks;
  int failures;

  mips_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .ALUSrc       (ALUSrc),
    .ALUOp        (ALUOp),
    .EXTOp        (EXTOp),
    .NPCOp        (NPCOp),
    .WDSel        (WDSel),
    .A3           (A3),
    .Tuse_rs      (Tuse_rs),
    .Tuse_rt      (Tuse_rt),
    .Tnew         (Tnew),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layout: RW MW AS ALU[3] EXT[4] NPC[3] WD[2] A3[5] TRS[2] TRT[2] TN[2] ILL
  logic [26:0] act;
  assign act = {RegWrite, MemWrite, ALUSrc, ALUOp, EXTOp, NPCOp, WDSel, A3,
                Tuse_rs, Tuse_rt, Tnew, illegal};

  function automatic logic [26:0] mk(input logic rw, input logic mw, input logic as_,
                                     input logic [2:0] alu, input logic [3:0] ext,
                                     input logic [2:0] npc, input logic [1:0] wd,
                                     input logic [4:0] a3, input logic [1:0] trs,
                                     input logic [1:0] trt, input logic [1:0] tn,
                                     input logic ill);
`ifndef DECODE_HAZARD_EN
    trs = 2'd0; trt = 2'd0; tn = 2'd0;
`endif
    return {rw, mw, as_, alu, ext, npc, wd, a3, trs, trt, tn, ill};
  endfunction

  // Reference model: name the instruction, then look up its control row
  function automatic logic [26:0] model(input logic [31:0] w);
    string m;
    logic [5:0] op, fn;
    logic [4:0] rtf, rdf;
    op = w[31:26]; fn = w[5:0]; rtf = w[20:16]; rdf = w[15:11];
    m = "bad";
    if (w == 32'd0) m = "nop";
    else if (op == 6'd0) begin
      if (fn == 6'h21) m = "addu";
      else if (fn == 6'h23) m = "subu";
      else if (fn == 6'h08) m = "jr";
    end
    else if (op == 6'h0D) m = "ori";
    else if (op == 6'h23) m = "lw";
    else if (op == 6'h2B) m = "sw";
    else if (op == 6'h04) m = "beq";
    else if (op == 6'h0F) m = "lui";
    else if (op == 6'h02) m = "j";
    else if (op == 6'h03) m = "jal";
    case (m)
      "addu": return mk(1,0,0,0,15,0,0,rdf,1,1,2,0);
      "subu": return mk(1,0,0,1,15,0,0,rdf,1,1,2,0);
      "jr":   return mk(0,0,0,0,15,3,0,0,  0,3,0,0);
      "ori":  return mk(1,0,1,2,0, 0,0,rtf,1,3,2,0);
      "lui":  return mk(1,0,1,0,2, 0,0,rtf,3,3,2,0);
      "lw":   return mk(1,0,1,0,1, 0,1,rtf,1,3,3,0);
      "sw":   return mk(0,1,1,0,1, 0,0,0,  1,2,0,0);
      "beq":  return mk(0,0,0,0,1, 1,0,0,  0,0,0,0);
      "j":    return mk(0,0,0,0,15,2,0,0,  3,3,0,0);
      "jal":  return mk(1,0,0,0,15,2,2,31, 3,3,1,0);
      "nop":  return mk(0,0,0,0,15,0,0,0,  3,3,0,0);
      default: return mk(0,0,0,0,15,0,0,0, 3,3,0,1);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];

  logic [5:0] ops[9];
  logic [5:0] fns[4];

  initial begin
    logic        seen_m;
    logic [31:0] w;
    logic [5:0]  op;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    instr = 32'd0;

    //            name         instr         rw mw as alu ext npc wd a3 trs trt tn ill
    vecs.push_back('{"ori",    32'h34A51234, mk(1,0,1,2,0, 0,0,5, 1,3,2,0)});
    vecs.push_back('{"jal",    32'h0C000C00, mk(1,0,0,0,15,2,2,31,3,3,1,0)});
    vecs.push_back('{"sw",     32'hAC280004, mk(0,1,1,0,1, 0,0,0, 1,2,0,0)});
    vecs.push_back('{"beq",    32'h1022FFFF, mk(0,0,0,0,1, 1,0,0, 0,0,0,0)});
    vecs.push_back('{"jr",     32'h03E00008, mk(0,0,0,0,15,3,0,0, 0,3,0,0)});
    vecs.push_back('{"illop",  32'hFC000000, mk(0,0,0,0,15,0,0,0, 3,3,0,1)});
    vecs.push_back('{"nop",    32'h00000000, mk(0,0,0,0,15,0,0,0, 3,3,0,0)});
    vecs.push_back('{"slt",    32'h0022182A, mk(0,0,0,0,15,0,0,0, 3,3,0,1)});
    vecs.push_back('{"addu",   32'h00221821, mk(1,0,0,0,15,0,0,3, 1,1,2,0)});
    vecs.push_back('{"subu",   32'h00221823, mk(1,0,0,1,15,0,0,3, 1,1,2,0)});
    vecs.push_back('{"lw",     32'h8C240008, mk(1,0,1,0,1, 0,1,4, 1,3,3,0)});
    vecs.push_back('{"lui",    32'h3C07ABCD, mk(1,0,1,0,2, 0,0,7, 3,3,2,0)});
    vecs.push_back('{"j",      32'h08000100, mk(0,0,0,0,15,2,0,0, 3,3,0,0)});
    vecs.push_back('{"ori_r0", 32'h34200001, mk(1,0,1,2,0, 0,0,0, 1,3,2,0)});

    // Reset phase: an illegal word during reset must not set the flag
    instr = 32'hFC000000;
    repeat (2) @(posedge clk);
    #1 chk("seen_in_reset", {31'd0, illegal_seen}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    instr = 32'd0;
    #1 chk("seen_after_reset", {31'd0, illegal_seen}, 32'd0);
    @(posedge clk);
    #1 chk("seen_idle_edge", {31'd0, illegal_seen}, 32'd0);

    // Vector table (legal entries first would not touch the flag anyway)
    foreach (vecs[i]) begin
      @(negedge clk);
      instr = vecs[i].instr;
      #1 chk(vecs[i].name, {5'd0, act}, {5'd0, vecs[i].exp});
    end

    // Clear the flag left by the illegal table entries
    @(negedge clk);
    instr = 32'd0;
    reset = 1'b1;
    #1 chk("async_clear", {31'd0, illegal_seen}, 32'd0);
    reset = 1'b0;

    // Single-cycle illegal: rises after the edge and sticks
    @(negedge clk);
    instr = 32'hFC000000;
    #1 chk("seen_before_edge", {31'd0, illegal_seen}, 32'd0);
    @(posedge clk);
    #1 chk("seen_rise", {31'd0, illegal_seen}, 32'd1);
    @(negedge clk);
    instr = 32'd0;
    @(posedge clk);
    #1 chk("seen_sticky", {31'd0, illegal_seen}, 32'd1);
    chk("decode_unaffected", {5'd0, act}, {5'd0, model(32'd0)});

    // Mid-cycle asynchronous reset pulse clears immediately
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("seen_async_reset", {31'd0, illegal_seen}, 32'd0);
    chk("decode_in_reset", {5'd0, act}, {5'd0, model(32'd0)});
    reset = 1'b0;
    @(posedge clk);
    #1 chk("seen_stays_clear", {31'd0, illegal_seen}, 32'd0);

    // Reset coinciding with an illegal instruction: reset wins
    @(negedge clk);
    instr = 32'h0000003F;
    reset = 1'b1;
    @(posedge clk);
    #1 chk("reset_wins", {31'd0, illegal_seen}, 32'd0);
    chk("illegal_in_reset", {31'd0, illegal}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("seen_after_release", {31'd0, illegal_seen}, 32'd1);
    @(negedge clk);
    instr = 32'd0;
    reset = 1'b1;
    #1 reset = 1'b0;

    // Randomized decode and sticky-flag tracking
    ops = '{6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h02, 6'h03, 6'h00, 6'h3F};
    fns = '{6'h21, 6'h23, 6'h08, 6'h00};
    seen_m = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      w = $urandom;
      if ($urandom_range(3) != 0) begin
        op = ops[$urandom_range(8)];
        if (op == 6'h3F) op = 6'($urandom);
        w[31:26] = op;
        if (op == 6'h00) begin
          w[5:0] = fns[$urandom_range(3)];
          if (w[5:0] == 6'h00) w[5:0] = 6'($urandom);
        end
      end
      if ($urandom_range(15) == 0) w = 32'd0;
      instr = w;
      if ($urandom_range(19) == 0) begin
        #1 reset = 1'b1;
        seen_m = 1'b0;
        #1 reset = 1'b0;
      end
      #1 chk("rand_decode", {5'd0, act}, {5'd0, model(w)});
      @(posedge clk);
      seen_m = seen_m | model(w)[0];
      #1 chk("rand_seen", {31'd0, illegal_seen}, {31'd0, seen_m});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
